// File: rtl/dac_sample_scheduler.sv
// Two-requester sample FIFO paced onto the DAC D bus by a programmable tick divider.
// Optional DAC_SCHED_MIDSCALE_EN: dac_d resets to, and parks at, mid-scale whenever playback goes idle.
module dac_sample_scheduler #(
    parameter int DATA_W     = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 8
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        req0_valid,
    input  logic [DATA_W-1:0]           req0_data,
    output logic                        req0_ready,
    input  logic                        req1_valid,
    input  logic [DATA_W-1:0]           req1_data,
    output logic                        req1_ready,
    input  logic                        enable,
    input  logic [DIV_W-1:0]            div,
    input  logic                        clr_underrun,
    output logic [DATA_W-1:0]           dac_d,
    output logic                        sample_strobe,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]     DEPTH_L  = LW'(FIFO_DEPTH);
    localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef DAC_SCHED_MIDSCALE_EN
    localparam logic [DATA_W-1:0] DAC_RESET = MIDSCALE;
`else
    localparam logic [DATA_W-1:0] DAC_RESET = '0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [LW-1:0]     level_q, level_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic              pref1_q, pref1_d;
    logic [DATA_W-1:0] dac_q, dac_d_nxt;
    logic              strobe_q, strobe_d;
    logic              underrun_q, underrun_d;

    logic              empty;
    logic              full;
    logic              grant0;
    logic              grant1;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              tick;
    logic              pop;

    // Full is judged on the registered level, so a popping cycle still refuses a push at full.
    always_comb begin
        empty      = (level_q == '0);
        full       = (level_q == DEPTH_L);
        grant1     = req1_valid && (!req0_valid || pref1_q);
        grant0     = req0_valid && !grant1;
        req0_ready = grant0 && !full && !reset;
        req1_ready = grant1 && !full && !reset;
        push       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        push_data  = req1_ready ? req1_data : req0_data;
        tick       = (state_q != IDLE) && (cnt_q == '0);
        pop        = tick && !empty;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        pref1_d  = pref1_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
            pref1_d         = req0_ready;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dac_d_nxt  = dac_q;
        strobe_d   = pop;
        underrun_d = underrun_q;

        if (pop) begin
            dac_d_nxt = mem_q[rd_ptr_q];
        end

        if (tick && empty && (state_q == RUN)) begin
            underrun_d = 1'b1;
        end else if (clr_underrun) begin
            underrun_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (enable && !empty) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = tick ? div : cnt_q - DIV_W'(1);
                if (!enable) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                cnt_d = tick ? div : cnt_q - DIV_W'(1);
                if (enable) begin
                    state_d = RUN;
                end else if (empty) begin
                    state_d = IDLE;
`ifdef DAC_SCHED_MIDSCALE_EN
                    dac_d_nxt = MIDSCALE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pref1_q    <= 1'b0;
            dac_q      <= DAC_RESET;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pref1_q    <= pref1_d;
            dac_q      <= dac_d_nxt;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
        end
    end

    // Storage needs no reset: entries are only read while the level says they are valid.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign dac_d         = dac_q;
    assign sample_strobe = strobe_q;
    assign underrun      = underrun_q;
    assign fifo_level    = level_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Self-checking bench for dac_sample_scheduler: directed scenarios plus random traffic against a queue-based model.
module tb_dac_sample_scheduler;

    localparam int DATA_W     = 10;
    localparam int FIFO_DEPTH = 8;
    localparam int DIV_W      = 8;
    localparam int LW         = 4;

    logic              CLK = 1'b0;
    logic              reset = 1'b1;
    logic              req0_valid = 1'b0;
    logic [DATA_W-1:0] req0_data = '0;
    logic              req0_ready;
    logic              req1_valid = 1'b0;
    logic [DATA_W-1:0] req1_data = '0;
    logic              req1_ready;
    logic              enable = 1'b0;
    logic [DIV_W-1:0]  div = '0;
    logic              clr_underrun = 1'b0;
    logic [DATA_W-1:0] dac_d;
    logic              sample_strobe;
    logic              underrun;
    logic [LW-1:0]     fifo_level;

    dac_sample_scheduler #(
        .DATA_W(DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .DIV_W(DIV_W)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .req0_valid(req0_valid),
        .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data(req1_data),
        .req1_ready(req1_ready),
        .enable(enable),
        .div(div),
        .clr_underrun(clr_underrun),
        .dac_d(dac_d),
        .sample_strobe(sample_strobe),
        .underrun(underrun),
        .fifo_level(fifo_level)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Reference model: sample queue, playback mode and countdown to the next tick.
    int mq[$];
    int m_mode = 0;      // 0 idle, 1 playing, 2 draining
    int m_cnt = 0;
    int m_dac = 0;
    int m_strobe = 0;
    int m_urun = 0;
    int m_pref1 = 0;
    int cyc = 0;
    bit obs_r0, obs_r1;

    function automatic int dac_rst();
`ifdef DAC_SCHED_MIDSCALE_EN
        return 512;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: compare DUT against model mid-cycle, then advance the model at the edge.
    task automatic cycle();
        int g;
        bit r0, r1, empty, full, tick, pop, push;
        #1;
        empty = (mq.size() == 0);
        full  = (mq.size() == FIFO_DEPTH);
        g = -1;
        if (req0_valid && !req1_valid) g = 0;
        else if (req1_valid && !req0_valid) g = 1;
        else if (req0_valid && req1_valid) g = m_pref1;
        r0 = (g == 0) && !full && !reset;
        r1 = (g == 1) && !full && !reset;
        obs_r0 = req0_ready;
        obs_r1 = req1_ready;
        check("req0_ready", int'(req0_ready), int'(r0));
        check("req1_ready", int'(req1_ready), int'(r1));
        check("dac_d", int'(dac_d), m_dac);
        check("sample_strobe", int'(sample_strobe), m_strobe);
        check("underrun", int'(underrun), m_urun);
        check("fifo_level", int'(fifo_level), mq.size());
        tick = (m_mode != 0) && (m_cnt == 0);
        pop  = tick && !empty;
        push = (r0 && req0_valid) || (r1 && req1_valid);
        @(posedge CLK);
        if (reset) begin
            mq.delete();
            m_mode = 0; m_cnt = 0; m_dac = dac_rst();
            m_strobe = 0; m_urun = 0; m_pref1 = 0;
        end else begin
            m_strobe = pop ? 1 : 0;
            if (pop) m_dac = mq.pop_front();
            if (push) begin
                mq.push_back(r1 ? int'(req1_data) : int'(req0_data));
                m_pref1 = r0 ? 1 : 0;
            end
            if (tick && empty && m_mode == 1) m_urun = 1;
            else if (clr_underrun) m_urun = 0;
            if (m_mode == 0) begin
                if (enable && !empty) begin
                    m_mode = 1;
                    m_cnt  = 0;
                end
            end else begin
                m_cnt = tick ? int'(div) : m_cnt - 1;
                if (m_mode == 1) begin
                    if (!enable) m_mode = 2;
                end else if (enable) begin
                    m_mode = 1;
                end else if (empty) begin
                    m_mode = 0;
`ifdef DAC_SCHED_MIDSCALE_EN
                    m_dac = 512;
`endif
                end
            end
        end
        @(negedge CLK);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        enable = 1'b0; clr_underrun = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic push0(input int val);
        req0_valid = 1'b1;
        req0_data  = DATA_W'(val);
        cycle();
        req0_valid = 1'b0;
    endtask

    initial begin
        int d0, d1, nstrobe, first_ur, last_st, prev_st;
        int vals[$];
        bit seen;

        @(negedge CLK);

        // Reset state, with both requesters asserting during reset.
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        cycle();
        check("rst_rdy0", int'(obs_r0), 0);
        check("rst_rdy1", int'(obs_r1), 0);
        do_reset();
        check("rst_dac", int'(dac_d), dac_rst());
        check("rst_strobe", int'(sample_strobe), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_level", int'(fifo_level), 0);

        // Single sample with div=3, then underrun and clear race.
        div = 8'd3;
        enable = 1'b1;
        push0(32'h155);                       // edge t
        cycle();                              // edge t+1
        cycle();                              // edge t+2
        check("single_dac", int'(dac_d), 32'h155);
        check("single_strobe", int'(sample_strobe), 1);
        check("single_level", int'(fifo_level), 0);
        nstrobe = 0;
        for (int i = 0; i < 3; i++) begin     // edges t+3..t+5
            cycle();
            nstrobe += int'(sample_strobe);
            check("single_no_urun", int'(underrun), 0);
        end
        check("single_one_strobe", nstrobe, 0);
        cycle();                              // edge t+6
        check("single_urun", int'(underrun), 1);
        for (int i = 0; i < 3; i++) cycle();  // edges t+7..t+9
        clr_underrun = 1'b1;
        cycle();                              // edge t+10: tick on empty FIFO
        check("race_set_wins", int'(underrun), 1);
        cycle();                              // edge t+11: clear alone
        check("clr_alone", int'(underrun), 0);
        clr_underrun = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // Contention: alternating grants starting with req0.
        do_reset();
        d0 = 32'h001; d1 = 32'h301;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req0_data = DATA_W'(d0);
            req1_data = DATA_W'(d1);
            cycle();
            check("arb_r1", int'(obs_r1), k % 2);
            check("arb_r0", int'(obs_r0), 1 - (k % 2));
            if (obs_r0) d0++;
            if (obs_r1) d1++;
        end
        cycle();
        check("full_level", int'(fifo_level), 8);
        check("full_rdy0", int'(obs_r0), 0);
        check("full_rdy1", int'(obs_r1), 0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Pacing: 8 queued samples, div=4.
        div = 8'd4;
        enable = 1'b1;
        nstrobe = 0; first_ur = -1; last_st = -1; prev_st = -1;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (sample_strobe) begin
                check("pace_value", int'(dac_d),
                      (nstrobe % 2 == 0) ? 32'h001 + nstrobe / 2 : 32'h301 + nstrobe / 2);
                if (prev_st >= 0) check("pace_interval", cyc - prev_st, 5);
                prev_st = cyc;
                last_st = cyc;
                nstrobe++;
            end
            if (underrun && first_ur < 0) first_ur = cyc;
        end
        check("pace_count", nstrobe, 8);
        check("pace_urun_gap", first_ur - last_st, 5);

        // Drain: enable drops after the first strobe.
        do_reset();
        div = 8'd2;
        for (int i = 0; i < 4; i++) push0(32'h0A0 + i);
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            seen = sample_strobe;
        end
        check("drain_first_strobe", int'(seen), 1);
        enable = 1'b0;
        nstrobe = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            nstrobe += int'(sample_strobe);
        end
        check("drain_strobes", nstrobe, 3);
`ifdef DAC_SCHED_MIDSCALE_EN
        check("drain_idle_dac", int'(dac_d), 32'h200);
`else
        check("drain_idle_dac", int'(dac_d), 32'h0A3);
`endif
        push0(32'h0B0);
        nstrobe = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            nstrobe += int'(sample_strobe);
        end
        check("idle_no_strobe", nstrobe, 0);
        check("idle_level", int'(fifo_level), 1);

        // Reset mid-run at level 5.
        do_reset();
        div = 8'd3;
        for (int i = 0; i < 5; i++) push0(32'h040 + i);
        check("pre_reset_level", int'(fifo_level), 5);
        enable = 1'b1;
        cycle();
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        cycle();
        check("midrst_rdy0", int'(obs_r0), 0);
        check("midrst_rdy1", int'(obs_r1), 0);
        reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("midrst_level", int'(fifo_level), 0);
        check("midrst_strobe", int'(sample_strobe), 0);
        check("midrst_urun", int'(underrun), 0);
        nstrobe = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            nstrobe += int'(sample_strobe) + int'(underrun);
        end
        check("midrst_idle", nstrobe, 0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            req0_valid   = ($urandom_range(0, 9) < 4);
            req1_valid   = ($urandom_range(0, 9) < 3);
            req0_data    = DATA_W'($urandom);
            req1_data    = DATA_W'($urandom);
            clr_underrun = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            if ($urandom_range(0, 49) == 0) div = DIV_W'($urandom_range(0, 5));
            reset = ($urandom_range(0, 499) == 0);
            cycle();
        end
        reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dac_sample_scheduler.md
# dac_sample_scheduler

Shares the 10-bit audio DAC in the babysoc between two sample sources, the rvmyth core output and a secondary requester (test/DMA port). Accepted samples go into a small FIFO. The block then paces them onto the DAC `D` bus at a programmable sample rate derived from the PLL clock. It sits between the core/requesters and `avsddac`, and all of its logic runs in the `CLK` domain.

## Interface
Parameters:
- `DATA_W`, 10: sample width; matches DAC `D`.
- `FIFO_DEPTH`, 8: FIFO entries; power of two, 2 to 64.
- `DIV_W`, 8: width of the sample-period divider.

Ports:
- `CLK`, input, 1: sole clock, driven by PLL.
- `reset`, input, 1: synchronous, active-high.
- `req0_valid`, input, 1: requester 0 (core) offers a sample.
- `req0_data`, input, DATA_W: requester 0 sample.
- `req0_ready`, output, 1: requester 0 sample accepted this cycle when `req0_valid` is also high.
- `req1_valid`, `req1_data`, `req1_ready`: same as the three above, for requester 1.
- `enable`, input, 1: playback enable.
- `div`, input, DIV_W: sample period minus 1, in `CLK` cycles.
- `clr_underrun`, input, 1: clears the sticky underrun flag.
- `dac_d`, output, DATA_W: registered value to DAC `D`.
- `sample_strobe`, output, 1: one-cycle pulse; high in the cycle `dac_d` takes a new value.
- `underrun`, output, 1: sticky flag; a playback tick found the FIFO empty.
- `fifo_level`, output, log2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Arbitration**
  - Grant is computed combinationally each cycle.
  - If only one valid is high, that requester is granted.
  - If both are high, grant goes to the requester not granted at the last accepted push (round-robin pointer). After reset the pointer favours req0.
  - `reqN_ready` = (grant == N) && !full && !reset. The non-granted requester's ready is 0.
  - At most one push per cycle. The pointer updates only on an accepted push.
- **FIFO**
  - Push on valid && ready; pop on tick && !empty.
  - Push and pop in the same cycle leave the level unchanged.
  - `full` is evaluated before the pop, so there is no bypass: a full FIFO refuses a push even in a cycle that pops.
- **State machine: IDLE, RUN, DRAIN**
  - IDLE: no ticks, `dac_d` held. Moves to RUN when `enable` && !empty; the tick counter is loaded with 0.
  - RUN: a tick fires when the counter is 0. On a tick the counter reloads from `div` (sampled at reload); otherwise it decrements. `enable` low moves the state to DRAIN.
  - DRAIN: ticks continue. Moves to IDLE when the FIFO is empty at a tick, or immediately if already empty. `enable` high moves the state back to RUN with the counter unchanged.
- **Tick effects**
  - If !empty: `dac_d` <= FIFO head, `sample_strobe` = 1 in the following cycle.
  - If empty in RUN: `dac_d` holds, no strobe, `underrun` set.
  - If set and `clr_underrun` occur in the same cycle, set wins.
- **Reset**: `reset` at any point flushes the FIFO, returns to IDLE, and clears the counter, pointer and flags. Data in flight is discarded.

## Timing
- Output values after reset:
  - `dac_d` = 0 (see Configuration).
  - `sample_strobe` = 0, `underrun` = 0, `fifo_level` = 0.
  - `req0_ready` = `req1_ready` = 0 while `reset` is high.
- Latency from IDLE: a push accepted at edge t moves the state to RUN at edge t+1, and `dac_d` updates at edge t+2. `sample_strobe` is high in the cycle after edge t+2.
- In steady RUN, `dac_d` updates every `div`+1 cycles; `div` = 0 gives an update every cycle.
- A change to `div` takes effect at the next reload only.
- `fifo_level` is registered and reflects pushes/pops at the same edge.

## Configuration
- `DAC_SCHED_MIDSCALE_EN` defined:
  - `dac_d` resets to 2^(DATA_W-1), i.e. 10'h200.
  - On every transition into IDLE (from DRAIN), `dac_d` is loaded with 2^(DATA_W-1) at the transition edge, with no strobe.
- Not defined: `dac_d` resets to 0 and holds the last sample in IDLE.

## Test plan
- Single sample: `div` = 3, `enable` = 1, req0 pushes 10'h155 at edge t. Required: `dac_d` = 10'h155 after edge t+2, strobe exactly once, FIFO then empty; next tick at t+6 sets `underrun`.
- Contention: both valid continuously, req0 data 10'h001 and up, req1 data 10'h301 and up, `enable` = 0. Required: pushes alternate 0,1,0,1… starting with req0; after 8 pushes `fifo_level` = 8 and both readies are 0.
- Pacing: FIFO pre-filled with 8 samples, `div` = 4, `enable` rises. Required: strobes exactly 5 cycles apart, values in push order, 8 strobes, then underrun on the 9th tick.
- Drain: 4 samples queued, RUN, `enable` drops after the first strobe. Required: 3 more strobes, then IDLE. With `DAC_SCHED_MIDSCALE_EN`, `dac_d` = 10'h200 after entering IDLE; without it, `dac_d` holds the 4th sample.
- Reset mid-run: FIFO at level 5, `reset` pulsed for 1 cycle. Required: `fifo_level` = 0, state IDLE, no strobe, `underrun` = 0, readies 0 during reset.
- Flag clear race: underrun tick and `clr_underrun` in the same cycle leave `underrun` = 1. `clr_underrun` alone in the next cycle clears it.
